// File: rtl/leaf_sched_pkg.sv
// Shared definitions for the leaf round-robin scheduler: default sizing
// constants and the scheduler state encoding.
package leaf_sched_pkg;

    localparam int DEF_NUM_REQ  = 5;
    localparam int DEF_HOLD_MAX = 16;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_IDX_W    = $clog2(DEF_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/leaf_rr_pick.sv
// Rotating priority encoder: finds the first set request at or after the
// pointer, wrapping from the last requester back to requester 0.
module leaf_rr_pick
    import leaf_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [IDX_W:0] w_cand;

    // Walk candidates in rotated order; the first hit wins and later hits are ignored.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!o_valid && i_req[w_cand[IDX_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/leaf_rr_scheduler.sv
// Round-robin scheduler sharing one downstream resource between the leaf
// instances of a hierarchy node. One owner at a time; a grant ends on
// release, on request drop, or when the hold limit expires, and is always
// followed by a single idle gap cycle before the next grant.
module leaf_rr_scheduler
    import leaf_sched_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int HOLD_MAX = DEF_HOLD_MAX,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         rel,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       busy,
    output logic                       timeout,
    output logic [CNT_W-1:0]           grant_cnt
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(HOLD_MAX);

    sched_state_t       r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_idx;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_cnt;

    sched_state_t       w_state_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic               w_timeout_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_own_req;
    logic               w_own_rel;
    logic               w_at_limit;

    leaf_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_own_req  = req[r_idx];
    assign w_own_rel  = rel[r_idx];
    assign w_at_limit = (r_hold == HOLD_W'(HOLD_MAX - 1));

    // Next-state logic: arbitrate in IDLE/GAP, supervise the owner in GRANT.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_idx;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            IDLE, GAP: begin
                w_gnt_nxt = '0;
                if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = NUM_REQ'(1) << w_pick_idx;
                    w_idx_nxt   = w_pick_idx;
                    w_hold_nxt  = '0;
                    if (r_cnt != {CNT_W{1'b1}}) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT: begin
                w_hold_nxt = r_hold + HOLD_W'(1);
                if (w_own_rel || !w_own_req || w_at_limit) begin
                    w_state_nxt   = GAP;
                    w_gnt_nxt     = '0;
                    w_hold_nxt    = '0;
                    w_ptr_nxt     = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
                    w_timeout_nxt = w_at_limit && w_own_req && !w_own_rel;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_idx     <= w_idx_nxt;
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign busy      = (r_state == GRANT);
    assign timeout   = r_timeout;
    assign grant_cnt = r_cnt;

endmodule

// File: tb/tb_leaf_rr_scheduler.sv
// Testbench for leaf_rr_scheduler: directed scenarios followed by random
// traffic, compared every cycle against a behavioural model of the
// grant-ownership rules through an expected-value queue.
module tb_leaf_rr_scheduler;

    localparam int NUM_REQ  = 5;
    localparam int HOLD_MAX = 16;
    localparam int CNT_W    = 4;
    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ-1:0] rel = '0;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               busy;
    logic               timeout;
    logic [CNT_W-1:0]   grant_cnt;

    typedef struct {
        int gnt;
        int idx;
        int busy;
        int timeout;
        int cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   fails  = 0;

    int mOwner   = -1;
    int mHeld    = 0;
    int mPtr     = 0;
    int mTimeout = 0;
    int mCnt     = 0;

    leaf_rr_scheduler #(
        .NUM_REQ  (NUM_REQ),
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .busy      (busy),
        .timeout   (timeout),
        .grant_cnt (grant_cnt)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the resource after this clock edge, given
    // this cycle's inputs. mHeld counts how many cycles the owner has had it.
    function automatic void modelStep(input bit r, input int rq, input int rl);
        int cand;
        if (r) begin
            mOwner   = -1;
            mHeld    = 0;
            mPtr     = 0;
            mTimeout = 0;
            mCnt     = 0;
        end else if (mOwner >= 0) begin
            bit ownRel;
            bit ownReq;
            ownRel   = ((rl >> mOwner) & 1) != 0;
            ownReq   = ((rq >> mOwner) & 1) != 0;
            mTimeout = 0;
            if (ownRel || !ownReq || mHeld == HOLD_MAX) begin
                mTimeout = (mHeld == HOLD_MAX && !ownRel && ownReq) ? 1 : 0;
                mPtr     = (mOwner + 1) % NUM_REQ;
                mOwner   = -1;
                mHeld    = 0;
            end else begin
                mHeld++;
            end
        end else begin
            mTimeout = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = (mPtr + k) % NUM_REQ;
                if (mOwner < 0 && ((rq >> cand) & 1) != 0) begin
                    mOwner = cand;
                end
            end
            if (mOwner >= 0) begin
                mHeld = 1;
                if (mCnt < CNT_MAX) mCnt++;
            end
        end
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic applyStimulus(input bit r, input logic [NUM_REQ-1:0] rq, input logic [NUM_REQ-1:0] rl);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        rel = rl;
        modelStep(r, int'(rq), int'(rl));
        e.gnt     = (mOwner >= 0) ? (1 << mOwner) : 0;
        e.idx     = mOwner;
        e.busy    = (mOwner >= 0) ? 1 : 0;
        e.timeout = mTimeout;
        e.cnt     = mCnt;
        expQ.push_back(e);
    endtask

    // Monitor: after every rising edge, pop the pending expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("gnt", int'(gnt), e.gnt);
                if (e.gnt != 0) checkOutput("gnt_idx", int'(gnt_idx), e.idx);
                checkOutput("busy", int'(busy), e.busy);
                checkOutput("timeout", int'(timeout), e.timeout);
                checkOutput("grant_cnt", int'(grant_cnt), e.cnt);
            end
        end
    end

    // Stimulus sequence: directed scenarios, then random traffic.
    initial begin
        logic [NUM_REQ-1:0] rq;
        logic [NUM_REQ-1:0] rl;

        $display("[TB] start");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, '0, '0);

        // Single request with a release pulse.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'b00100, '0);
        applyStimulus(1'b0, 5'b00100, 5'b00100);
        applyStimulus(1'b0, 5'b00000, '0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, '0);

        // Rotation with all requesters, each owner releasing after 3 cycles.
        applyStimulus(1'b1, '0, '0);
        for (int i = 0; i < 30; i++) begin
            rl = (mOwner >= 0 && mHeld == 3) ? NUM_REQ'(1 << mOwner) : '0;
            applyStimulus(1'b0, 5'b11111, rl);
        end

        // Hold-limit timeout and re-grant to the same requester.
        applyStimulus(1'b1, '0, '0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 5'b00001, '0);

        // Foreign release and foreign request drop leave the owner alone.
        applyStimulus(1'b1, '0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b11010, '0);
        applyStimulus(1'b0, 5'b01010, 5'b01000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b01010, '0);

        // Release coinciding with the hold limit.
        applyStimulus(1'b1, '0, '0);
        for (int i = 0; i < 22; i++) begin
            rl = (mOwner == 0 && mHeld == HOLD_MAX) ? 5'b00001 : '0;
            applyStimulus(1'b0, 5'b00001, rl);
        end

        // Reset while requester 3 owns the resource.
        applyStimulus(1'b1, '0, '0);
        applyStimulus(1'b0, 5'b00001, 5'b00001);
        applyStimulus(1'b0, 5'b01000, '0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'b01000, '0);
        applyStimulus(1'b1, 5'b01000, '0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'b11111, '0);

        // Random traffic; rare resets so the grant counter saturates.
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = NUM_REQ'($urandom);
            rl = ($urandom_range(0, 7) == 0) ? NUM_REQ'($urandom) : '0;
            applyStimulus($urandom_range(0, 499) == 0, rq, rl);
        end

        @(negedge clk);
        @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
